// File: rtl/pbus_pkg.sv
// Shared types and constants for the parallel-bus configuration sequencer.
package pbus_pkg;

  localparam logic CMD_WR = 1'b0;
  localparam logic CMD_RD = 1'b1;

  localparam int TIMEOUT_CYCLES_DEF = 1024;

  function automatic int tmo_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int TMO_W_DEF = tmo_width(TIMEOUT_CYCLES_DEF);

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_LOAD,
    HS_FIN
  } hs_state_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_T_ISSUE,
    S_T_WAIT,
    S_V_ISSUE,
    S_V_WAIT,
    S_NEXT,
    S_H_ISSUE,
    S_H_WAIT
  } seq_state_t;

endpackage

// File: rtl/pbus_cfg_sequencer_if.sv
// Engine-side bus of the sequencer: command/address/data out, busy/finish/rdata back.
interface pbus_cfg_sequencer_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  eng_load;
  logic                  eng_wr_cmd;
  logic [ADDR_WIDTH-1:0] eng_addr;
  logic [DATA_WIDTH-1:0] eng_wdata;
  logic [DATA_WIDTH-1:0] eng_rdata;
  logic                  eng_busy;
  logic                  eng_finish;

  modport master (
    output eng_load, eng_wr_cmd, eng_addr, eng_wdata,
    input  eng_rdata, eng_busy, eng_finish
  );

  modport slave (
    input  eng_load, eng_wr_cmd, eng_addr, eng_wdata,
    output eng_rdata, eng_busy, eng_finish
  );
endinterface

// File: rtl/pbus_handshake.sv
// One engine operation: hold load until busy, then wait for finish; each phase
// has its own timeout window.
module pbus_handshake
  import pbus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_go,
  input  logic i_busy,
  input  logic i_finish,
  output logic o_load,
  output logic o_done,
  output logic o_tmo
);
  localparam int            CW      = tmo_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  hs_state_t     r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic          w_cnt_max;

  assign w_cnt_max = (r_cnt == CNT_MAX);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= HS_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // Load is decoded from state so an async reset drops it immediately.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt + CW'(1);
    o_load     = 1'b0;
    o_done     = 1'b0;
    o_tmo      = 1'b0;
    unique case (r_state)
      HS_IDLE: begin
        w_cnt_nx = '0;
        if (i_go) w_state_nx = HS_LOAD;
      end
      HS_LOAD: begin
        o_load = 1'b1;
        if (i_busy) begin
          w_state_nx = HS_FIN;
          w_cnt_nx   = '0;
        end else if (w_cnt_max) begin
          o_tmo      = 1'b1;
          w_state_nx = HS_IDLE;
        end
      end
      HS_FIN: begin
        if (i_finish) begin
          o_done     = 1'b1;
          w_state_nx = HS_IDLE;
        end else if (w_cnt_max) begin
          o_tmo      = 1'b1;
          w_state_nx = HS_IDLE;
        end
      end
      default: w_state_nx = HS_IDLE;
    endcase
  end

endmodule

// File: rtl/pbus_cfg_sequencer.sv
// Replays an (addr,data) table into the bus engine and interleaves host ops.
// Build option PBUS_VERIFY_EN: read back every table write and flag mismatches.
module pbus_cfg_sequencer
  import pbus_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int IDX_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [IDX_WIDTH:0]    i_run_len,
  output logic [IDX_WIDTH-1:0]  o_tbl_idx,
  input  logic [ADDR_WIDTH-1:0] i_tbl_addr,
  input  logic [DATA_WIDTH-1:0] i_tbl_data,
  input  logic                  i_host_req,
  input  logic                  i_host_wr_cmd,
  input  logic [ADDR_WIDTH-1:0] i_host_addr,
  input  logic [DATA_WIDTH-1:0] i_host_wdata,
  output logic                  o_host_ack,
  output logic [DATA_WIDTH-1:0] o_host_rdata,
  output logic                  o_seq_busy,
  output logic                  o_seq_done,
  output logic                  o_seq_err,
`ifdef PBUS_VERIFY_EN
  output logic [IDX_WIDTH-1:0]  o_err_idx,
`endif
  pbus_cfg_sequencer_if.master  eng
);

  seq_state_t            r_state, w_state_nx;
  logic [IDX_WIDTH-1:0]  r_idx, w_idx_nx;
  logic [IDX_WIDTH:0]    r_len, w_len_nx;
  logic [IDX_WIDTH:0]    w_idx_p1;
  logic                  r_run, w_run_nx;
  logic                  r_err, w_err_nx;
  logic                  r_done, w_done_nx;
  logic                  r_ack, w_ack_nx;
  logic                  r_last_host, w_last_host_nx;
  logic [DATA_WIDTH-1:0] r_rdata, w_rdata_nx;
  logic                  r_cmd, w_cmd_nx;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nx;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nx;
`ifdef PBUS_VERIFY_EN
  logic [IDX_WIDTH-1:0]  r_err_idx, w_err_idx_nx;
`endif
  logic                  w_go, w_hs_done, w_hs_tmo, w_load;

  pbus_handshake #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_hs (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_go     (w_go),
    .i_busy   (eng.eng_busy),
    .i_finish (eng.eng_finish),
    .o_load   (w_load),
    .o_done   (w_hs_done),
    .o_tmo    (w_hs_tmo)
  );

  assign w_idx_p1 = {1'b0, r_idx} + (IDX_WIDTH+1)'(1);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_len       <= '0;
      r_run       <= 1'b0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
      r_ack       <= 1'b0;
      r_last_host <= 1'b0;
      r_rdata     <= '0;
      r_cmd       <= CMD_WR;
      r_addr      <= '0;
      r_wdata     <= '0;
`ifdef PBUS_VERIFY_EN
      r_err_idx   <= '0;
`endif
    end else begin
      r_state     <= w_state_nx;
      r_idx       <= w_idx_nx;
      r_len       <= w_len_nx;
      r_run       <= w_run_nx;
      r_err       <= w_err_nx;
      r_done      <= w_done_nx;
      r_ack       <= w_ack_nx;
      r_last_host <= w_last_host_nx;
      r_rdata     <= w_rdata_nx;
      r_cmd       <= w_cmd_nx;
      r_addr      <= w_addr_nx;
      r_wdata     <= w_wdata_nx;
`ifdef PBUS_VERIFY_EN
      r_err_idx   <= w_err_idx_nx;
`endif
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_idx_nx       = r_idx;
    w_len_nx       = r_len;
    w_run_nx       = r_run;
    w_err_nx       = r_err;
    w_done_nx      = 1'b0;
    w_ack_nx       = 1'b0;
    w_last_host_nx = r_last_host;
    w_rdata_nx     = r_rdata;
    w_cmd_nx       = r_cmd;
    w_addr_nx      = r_addr;
    w_wdata_nx     = r_wdata;
`ifdef PBUS_VERIFY_EN
    w_err_idx_nx   = r_err_idx;
`endif
    w_go           = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_err_nx       = 1'b0;
          w_idx_nx       = '0;
          w_len_nx       = i_run_len;
          w_last_host_nx = 1'b0;
          if (i_run_len == '0) begin
            w_done_nx = 1'b1;
          end else begin
            w_run_nx   = 1'b1;
            w_state_nx = S_FETCH;
          end
        end else if (i_host_req) begin
          w_state_nx = S_H_ISSUE;
        end
      end
      // ROM output for the new index lands during this cycle.
      S_FETCH: w_state_nx = S_T_ISSUE;
      S_T_ISSUE: begin
        w_cmd_nx       = CMD_WR;
        w_addr_nx      = i_tbl_addr;
        w_wdata_nx     = i_tbl_data;
        w_last_host_nx = 1'b0;
        w_go           = 1'b1;
        w_state_nx     = S_T_WAIT;
      end
      S_T_WAIT: begin
        if (w_hs_tmo) begin
          w_err_nx   = 1'b1;
          w_done_nx  = 1'b1;
          w_run_nx   = 1'b0;
          w_state_nx = S_IDLE;
        end else if (w_hs_done) begin
`ifdef PBUS_VERIFY_EN
          w_state_nx = S_V_ISSUE;
`else
          w_state_nx = S_NEXT;
`endif
        end
      end
`ifdef PBUS_VERIFY_EN
      // Readback keeps r_wdata as the compare reference.
      S_V_ISSUE: begin
        w_cmd_nx   = CMD_RD;
        w_go       = 1'b1;
        w_state_nx = S_V_WAIT;
      end
      S_V_WAIT: begin
        if (w_hs_tmo) begin
          w_err_nx   = 1'b1;
          w_done_nx  = 1'b1;
          w_run_nx   = 1'b0;
          w_state_nx = S_IDLE;
        end else if (w_hs_done) begin
          if (eng.eng_rdata != r_wdata) begin
            w_err_nx     = 1'b1;
            w_err_idx_nx = r_idx;
          end
          w_state_nx = S_NEXT;
        end
      end
`endif
      S_NEXT: begin
        if (w_idx_p1 == r_len) begin
          w_done_nx  = 1'b1;
          w_run_nx   = 1'b0;
          w_state_nx = S_IDLE;
        end else if (i_host_req && !r_last_host) begin
          w_state_nx = S_H_ISSUE;
        end else begin
          w_idx_nx   = r_idx + IDX_WIDTH'(1);
          w_state_nx = S_FETCH;
        end
      end
      S_H_ISSUE: begin
        w_cmd_nx       = i_host_wr_cmd;
        w_addr_nx      = i_host_addr;
        w_wdata_nx     = i_host_wdata;
        w_last_host_nx = 1'b1;
        w_go           = 1'b1;
        w_state_nx     = S_H_WAIT;
      end
      S_H_WAIT: begin
        if (w_hs_tmo || w_hs_done) begin
          w_ack_nx = 1'b1;
          if (w_hs_tmo) w_err_nx = 1'b1;
          else if (r_cmd == CMD_RD) w_rdata_nx = eng.eng_rdata;
          if (r_run) begin
            w_idx_nx   = r_idx + IDX_WIDTH'(1);
            w_state_nx = S_FETCH;
          end else begin
            w_state_nx = S_IDLE;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign o_tbl_idx      = r_idx;
  assign o_host_ack     = r_ack;
  assign o_host_rdata   = r_rdata;
  assign o_seq_busy     = r_run;
  assign o_seq_done     = r_done;
  assign o_seq_err      = r_err;
`ifdef PBUS_VERIFY_EN
  assign o_err_idx      = r_err_idx;
`endif
  assign eng.eng_load   = w_load;
  assign eng.eng_wr_cmd = r_cmd;
  assign eng.eng_addr   = r_addr;
  assign eng.eng_wdata  = r_wdata;

endmodule

// File: tb/tb_pbus_cfg_sequencer.sv
// Directed bench for pbus_cfg_sequencer with a behavioural bus-engine model.
// Define PBUS_VERIFY_EN for both RTL and bench to cover the readback build.
module tb_pbus_cfg_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [4:0] run_len;
  logic [3:0] tbl_idx;
  logic [7:0] tbl_addr, tbl_data;
  logic       host_req, host_wr_cmd;
  logic [7:0] host_addr, host_wdata;
  logic       host_ack;
  logic [7:0] host_rdata;
  logic       seq_busy, seq_done, seq_err;
`ifdef PBUS_VERIFY_EN
  logic [3:0] err_idx;
`endif

  pbus_cfg_sequencer_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

  pbus_cfg_sequencer #(
    .ADDR_WIDTH(8), .DATA_WIDTH(8), .IDX_WIDTH(4), .TIMEOUT_CYCLES(1024)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_start      (start),
    .i_run_len    (run_len),
    .o_tbl_idx    (tbl_idx),
    .i_tbl_addr   (tbl_addr),
    .i_tbl_data   (tbl_data),
    .i_host_req   (host_req),
    .i_host_wr_cmd(host_wr_cmd),
    .i_host_addr  (host_addr),
    .i_host_wdata (host_wdata),
    .o_host_ack   (host_ack),
    .o_host_rdata (host_rdata),
    .o_seq_busy   (seq_busy),
    .o_seq_done   (seq_done),
    .o_seq_err    (seq_err),
`ifdef PBUS_VERIFY_EN
    .o_err_idx    (err_idx),
`endif
    .eng          (bus)
  );

  always #5 clk = ~clk;

  // Synchronous ROM, one cycle latency.
  logic [7:0] rom_a [16];
  logic [7:0] rom_d [16];
  always @(posedge clk) begin
    tbl_addr <= rom_a[tbl_idx];
    tbl_data <= rom_d[tbl_idx];
  end

  // Engine model: busy after busy_dly cycles of load, finish pulse after fin_dly
  // busy cycles, then one re-arm gap cycle.
  int         busy_dly = 1;
  int         fin_dly  = 2;
  logic       m_never  = 1'b0;
  logic       m_corrupt = 1'b0;
  logic [7:0] m_corrupt_addr = 8'h00;
  logic [7:0] m_mem [256];
  logic [16:0] m_wlog [64];
  logic [16:0] m_last_op;
  int         m_wn, m_n, m_ph, m_cnt;

  function automatic logic [7:0] rd_val(input logic [7:0] a, input logic [7:0] stored);
    logic [7:0] v;
    v = (a == 8'h20) ? 8'h5A : stored;
    if (m_corrupt && a == m_corrupt_addr) v = v ^ 8'hFF;
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.eng_busy   <= 1'b0;
      bus.eng_finish <= 1'b0;
      bus.eng_rdata  <= 8'h00;
      m_wn <= 0; m_n <= 0; m_ph <= 0; m_cnt <= 0;
      m_last_op <= '0;
    end else begin
      bus.eng_finish <= 1'b0;
      case (m_ph)
        0: begin
          if (bus.eng_load && !m_never) begin
            if (m_cnt >= busy_dly) begin
              bus.eng_busy <= 1'b1;
              m_ph  <= 1;
              m_cnt <= 0;
              m_n   <= m_n + 1;
              m_last_op <= {bus.eng_wr_cmd, bus.eng_addr, bus.eng_wdata};
              if (!bus.eng_wr_cmd) begin
                m_wlog[m_wn[5:0]]    <= {bus.eng_wr_cmd, bus.eng_addr, bus.eng_wdata};
                m_wn                 <= m_wn + 1;
                m_mem[bus.eng_addr]  <= bus.eng_wdata;
              end
            end else m_cnt <= m_cnt + 1;
          end else m_cnt <= 0;
        end
        1: begin
          if (m_cnt >= fin_dly) begin
            bus.eng_busy   <= 1'b0;
            bus.eng_finish <= 1'b1;
            if (bus.eng_wr_cmd) bus.eng_rdata <= rd_val(bus.eng_addr, m_mem[bus.eng_addr]);
            m_ph  <= 2;
            m_cnt <= 0;
          end else m_cnt <= m_cnt + 1;
        end
        default: m_ph <= 0;
      endcase
    end
  end

  int done_cnt = 0;
  int ack_cnt  = 0;
  always @(posedge clk) begin
    done_cnt <= done_cnt + int'(seq_done);
    ack_cnt  <= ack_cnt + int'(host_ack);
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int d0, a0, w0, n0;

  initial begin
    rst_n = 1'b0; start = 1'b0; run_len = '0;
    host_req = 1'b0; host_wr_cmd = 1'b0; host_addr = '0; host_wdata = '0;
    for (int i = 0; i < 16; i++) begin rom_a[i] = 8'h00; rom_d[i] = 8'h00; end
    #3;
    chk("rst_load",  {31'd0, bus.eng_load}, 32'd0);
    chk("rst_busy",  {31'd0, seq_busy}, 32'd0);
    chk("rst_done",  {31'd0, seq_done}, 32'd0);
    chk("rst_err",   {31'd0, seq_err}, 32'd0);
    chk("rst_ack",   {31'd0, host_ack}, 32'd0);
    chk("rst_idx",   {28'd0, tbl_idx}, 32'd0);
    chk("rst_rdata", {24'd0, host_rdata}, 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // 1: three-entry run; a stray start mid-run must be ignored
    rom_a[0] = 8'h10; rom_d[0] = 8'hA1;
    rom_a[1] = 8'h11; rom_d[1] = 8'hB2;
    rom_a[2] = 8'h12; rom_d[2] = 8'hC3;
    d0 = done_cnt; w0 = m_wn;
    start = 1'b1; run_len = 5'd3;
    tick();
    start = 1'b0;
    chk("t1_busy", {31'd0, seq_busy}, 32'd1);
    tick(); tick();
    start = 1'b1; run_len = 5'd1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 300 && done_cnt == d0; i++) tick();
    repeat (3) tick();
    chk("t1_done_cnt", done_cnt - d0, 32'd1);
    chk("t1_nwr", m_wn - w0, 32'd3);
    chk("t1_wr0", {15'd0, m_wlog[w0]},   {15'd0, 17'h010A1});
    chk("t1_wr1", {15'd0, m_wlog[w0+1]}, {15'd0, 17'h011B2});
    chk("t1_wr2", {15'd0, m_wlog[w0+2]}, {15'd0, 17'h012C3});
    chk("t1_err", {31'd0, seq_err}, 32'd0);
    chk("t1_idle", {31'd0, seq_busy}, 32'd0);

    // 2: host read while idle
    a0 = ack_cnt; n0 = m_n;
    host_wr_cmd = 1'b1; host_addr = 8'h20; host_req = 1'b1;
    for (int i = 0; i < 100 && host_ack !== 1'b1; i++) tick();
    host_req = 1'b0;
    chk("t2_ack", {31'd0, host_ack}, 32'd1);
    chk("t2_rdata", {24'd0, host_rdata}, 32'h5A);
    repeat (4) tick();
    chk("t2_ack_cnt", ack_cnt - a0, 32'd1);
    chk("t2_ops", m_n - n0, 32'd1);
    chk("t2_op", {15'd0, m_last_op}, {15'd0, 17'h12000});

    // 3: host write requested together with start: after entry 0, exactly once
    rom_a[0] = 8'h30; rom_d[0] = 8'h01;
    rom_a[1] = 8'h31; rom_d[1] = 8'h02;
    rom_a[2] = 8'h32; rom_d[2] = 8'h03;
    rom_a[3] = 8'h33; rom_d[3] = 8'h04;
    d0 = done_cnt; a0 = ack_cnt; w0 = m_wn;
    host_wr_cmd = 1'b0; host_addr = 8'h40; host_wdata = 8'h77; host_req = 1'b1;
    start = 1'b1; run_len = 5'd4;
    tick();
    start = 1'b0;
    for (int i = 0; i < 500 && done_cnt == d0; i++) begin
      tick();
      if (host_ack === 1'b1) host_req = 1'b0;
    end
    host_req = 1'b0;
    repeat (3) tick();
    chk("t3_done_cnt", done_cnt - d0, 32'd1);
    chk("t3_ack_cnt", ack_cnt - a0, 32'd1);
    chk("t3_nwr", m_wn - w0, 32'd5);
    chk("t3_wr0", {15'd0, m_wlog[w0]},   {15'd0, 17'h03001});
    chk("t3_wr1", {15'd0, m_wlog[w0+1]}, {15'd0, 17'h04077});
    chk("t3_wr2", {15'd0, m_wlog[w0+2]}, {15'd0, 17'h03102});
    chk("t3_wr3", {15'd0, m_wlog[w0+3]}, {15'd0, 17'h03203});
    chk("t3_wr4", {15'd0, m_wlog[w0+4]}, {15'd0, 17'h03304});
    chk("t3_err", {31'd0, seq_err}, 32'd0);

    // 4: engine never goes busy -> timeout after 1024 cycles of load
    m_never = 1'b1;
    d0 = done_cnt;
    start = 1'b1; run_len = 5'd1;
    tick();
    start = 1'b0;
    repeat (995) tick();
    chk("t4_no_early_done", done_cnt - d0, 32'd0);
    chk("t4_load_held", {31'd0, bus.eng_load}, 32'd1);
    for (int i = 0; i < 100 && seq_done !== 1'b1; i++) tick();
    chk("t4_done", {31'd0, seq_done}, 32'd1);
    chk("t4_err", {31'd0, seq_err}, 32'd1);
    chk("t4_load_drop", {31'd0, bus.eng_load}, 32'd0);
    m_never = 1'b0;
    repeat (3) tick();

    // 5: zero-length run finishes the cycle after start and clears err
    n0 = m_n;
    start = 1'b1; run_len = 5'd0;
    tick();
    start = 1'b0;
    chk("t5_done", {31'd0, seq_done}, 32'd1);
    chk("t5_err_clr", {31'd0, seq_err}, 32'd0);
    chk("t5_load", {31'd0, bus.eng_load}, 32'd0);
    chk("t5_busy", {31'd0, seq_busy}, 32'd0);
    tick();
    chk("t5_done_pulse", {31'd0, seq_done}, 32'd0);
    repeat (3) tick();
    chk("t5_no_ops", m_n - n0, 32'd0);

`ifdef PBUS_VERIFY_EN
    // 6: corrupted readback of entry 1 flags err with err_idx, run completes
    rom_a[0] = 8'h50; rom_d[0] = 8'h11;
    rom_a[1] = 8'h51; rom_d[1] = 8'h22;
    rom_a[2] = 8'h52; rom_d[2] = 8'h33;
    m_corrupt = 1'b1; m_corrupt_addr = 8'h51;
    d0 = done_cnt; w0 = m_wn; n0 = m_n;
    start = 1'b1; run_len = 5'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 500 && done_cnt == d0; i++) tick();
    repeat (3) tick();
    chk("t6_done_cnt", done_cnt - d0, 32'd1);
    chk("t6_nwr", m_wn - w0, 32'd3);
    chk("t6_nops", m_n - n0, 32'd6);
    chk("t6_wr2", {15'd0, m_wlog[w0+2]}, {15'd0, 17'h05233});
    chk("t6_err", {31'd0, seq_err}, 32'd1);
    chk("t6_err_idx", {28'd0, err_idx}, 32'd1);
    m_corrupt = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
